input_debouncer: RTL and testbench

Conditions the DE2 board's raw push-button and slide-switch inputs before they reach the CPU's memory-mapped I/O (`io_btn`, `io_sw`). It sits between the top-level `KEY`/`SW` pins and the `singlecycle` core. Each channel gets a two-flop synchronizer and a per-channel debounce counter. The block also produces a one-cycle press pulse per button, for edge-triggered firmware polling.

---
 rtl/input_debouncer.sv | 140 ++++++++++++++
 tb/tb_input_debouncer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions the raw DE2 push-buttons (KEY) and slide switches (SW) before
// they are exposed to the CPU as memory-mapped I/O. Every input bit passes
// through a two-flop synchronizer. Each button then has its own debounce
// counter that accepts a new level only after DEBOUNCE_CYCLES consecutive
// cycles of disagreement with the current stable level. Each button also
// produces a registered one-cycle pulse on every accepted press (1->0).
//
// Optional feature macro: SW_DEBOUNCE_EN
//   defined   : switches get the same per-channel debounce counters as buttons
//   undefined : switches are only synchronized (2-cycle latency, no filtering)
//
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a new level (>= 2)
//   N_BTN           : number of push-button channels
//   N_SW            : number of slide-switch channels (<= 32)
//
// Ports:
//   clk       : system clock (CLOCK_50)
//   rst       : asynchronous active-high reset
//   KEY       : raw buttons, active-low, asynchronous to clk
//   SW        : raw switches, active-high, asynchronous to clk
//   io_btn    : debounced button levels, active-low
//   btn_press : one-cycle pulse per accepted button press
//   io_sw     : switch levels, zero-extended to 32 bits
// -----------------------------------------------------------------------------
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int N_BTN           = 4,
  parameter int N_SW            = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] KEY,
  input  logic [N_SW-1:0]  SW,
  output logic [N_BTN-1:0] io_btn,
  output logic [N_BTN-1:0] btn_press,
  output logic [31:0]      io_sw
);

  localparam int          CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N_BTN-1:0] r_btnMeta;
  logic [N_BTN-1:0] r_btnSync;
  logic [N_BTN-1:0] r_btnStable;
  logic [N_BTN-1:0] r_btnPress;
  logic [CW-1:0]    r_btnCnt [N_BTN];

  logic [N_SW-1:0]  r_swMeta;
  logic [N_SW-1:0]  r_swSync;
  logic [N_SW-1:0]  w_swLevel;

  // Two-flop synchronizers. Buttons idle high (released), switches idle low,
  // so reset values match the idle level and no spurious press is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btnMeta <= '1;
      r_btnSync <= '1;
      r_swMeta  <= '0;
      r_swSync  <= '0;
    end else begin
      r_btnMeta <= KEY;
      r_btnSync <= r_btnMeta;
      r_swMeta  <= SW;
      r_swSync  <= r_swMeta;
    end
  end

  // Button debounce: the counter only advances while the synchronized level
  // disagrees with the accepted level; any agreement clears it, so a bouncing
  // contact restarts the window. On acceptance the press pulse is raised
  // exactly when the accepted level was 1 (i.e. the new level is 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btnStable <= '1;
      r_btnPress  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_btnCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_btnPress[i] <= 1'b0;
        if (r_btnSync[i] == r_btnStable[i]) begin
          r_btnCnt[i] <= '0;
        end else if (r_btnCnt[i] < CNT_MAX) begin
          r_btnCnt[i] <= r_btnCnt[i] + CNT_ONE;
        end else begin
          r_btnStable[i] <= r_btnSync[i];
          r_btnCnt[i]    <= '0;
          r_btnPress[i]  <= r_btnStable[i];
        end
      end
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [N_SW-1:0] r_swStable;
  logic [CW-1:0]   r_swCnt [N_SW];

  // Switch debounce, same acceptance rule as the buttons but no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swStable <= '0;
      for (int i = 0; i < N_SW; i++) begin
        r_swCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (r_swSync[i] == r_swStable[i]) begin
          r_swCnt[i] <= '0;
        end else if (r_swCnt[i] < CNT_MAX) begin
          r_swCnt[i] <= r_swCnt[i] + CNT_ONE;
        end else begin
          r_swStable[i] <= r_swSync[i];
          r_swCnt[i]    <= '0;
        end
      end
    end
  end

  assign w_swLevel = r_swStable;
`else
  // Without filtering the synchronizer output is the switch level.
  assign w_swLevel = r_swSync;
`endif

  assign io_btn    = r_btnStable;
  assign btn_press = r_btnPress;

  // Zero-extend the switch bank into the 32-bit I/O word.
  always_comb begin
    io_sw             = '0;
    io_sw[N_SW-1:0]   = w_swLevel;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer with DEBOUNCE_CYCLES = 8. A table of
// {KEY, SW, cycles, expected outputs} records covers the straightforward
// level behaviour; hand-written sequences cover glitch rejection, bouncing,
// the acceptance boundary and reset in the middle of a count. Works with and
// without SW_DEBOUNCE_EN; the expected switch latency follows the macro.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

  localparam int DC = 8;
  localparam int NB = 4;
  localparam int NS = 17;
`ifdef SW_DEBOUNCE_EN
  localparam int SW_LAT = DC + 2;
`else
  localparam int SW_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] KEY;
  logic [NS-1:0] SW;
  logic [NB-1:0] io_btn;
  logic [NB-1:0] btn_press;
  logic [31:0]   io_sw;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NB-1:0] key;
    logic [NS-1:0] sw;
    int            cycles;
    logic [NB-1:0] expBtn;
    logic [NB-1:0] expPress;
    logic [31:0]   expSw;
  } vec_t;

  vec_t vecs[$];

  // 100 MHz-style bench clock; only the edge count matters.
  always #5 clk = ~clk;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .N_BTN(NB),
    .N_SW(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .KEY(KEY),
    .SW(SW),
    .io_btn(io_btn),
    .btn_press(btn_press),
    .io_sw(io_sw)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] k, input logic [NS-1:0] s, input int n);
    KEY = k;
    SW  = s;
    step(n);
  endtask

  task automatic checkOutput(input string tag, input logic [NB-1:0] eb,
                             input logic [NB-1:0] ep, input logic [31:0] es);
    checkVal({tag, "_io_btn"},    32'(io_btn),    32'(eb));
    checkVal({tag, "_btn_press"}, 32'(btn_press), 32'(ep));
    checkVal({tag, "_io_sw"},     io_sw,          es);
  endtask

  initial begin
    int fallAt;
    int pressAt;
    int pressCnt;
    int fallCnt;
    int glitchCnt;
    logic prevBtn;

    rst = 1'b1;
    KEY = 4'hF;
    SW  = '0;
    step(2);
    checkOutput("reset", 4'hF, 4'h0, 32'h0);
    #2 rst = 1'b0;

    // Table: KEY[0] press/release, two simultaneous presses, switch levels.
    vecs.push_back('{4'hF, 17'h0,     2,          4'hF, 4'h0, 32'h0});
    vecs.push_back('{4'hE, 17'h0,     DC + 1,     4'hF, 4'h0, 32'h0});
    vecs.push_back('{4'hE, 17'h0,     1,          4'hE, 4'h1, 32'h0});
    vecs.push_back('{4'hE, 17'h0,     1,          4'hE, 4'h0, 32'h0});
    vecs.push_back('{4'hF, 17'h0,     DC + 1,     4'hE, 4'h0, 32'h0});
    vecs.push_back('{4'hF, 17'h0,     1,          4'hF, 4'h0, 32'h0});
    vecs.push_back('{4'h9, 17'h0,     DC + 2,     4'h9, 4'h6, 32'h0});
    vecs.push_back('{4'h9, 17'h0,     1,          4'h9, 4'h0, 32'h0});
    vecs.push_back('{4'hF, 17'h0,     DC + 2,     4'hF, 4'h0, 32'h0});
    vecs.push_back('{4'hF, 17'h20,    SW_LAT - 1, 4'hF, 4'h0, 32'h0});
    vecs.push_back('{4'hF, 17'h20,    1,          4'hF, 4'h0, 32'h20});
    vecs.push_back('{4'hF, 17'h1FFFF, SW_LAT - 1, 4'hF, 4'h0, 32'h20});
    vecs.push_back('{4'hF, 17'h1FFFF, 1,          4'hF, 4'h0, 32'h0001FFFF});
    vecs.push_back('{4'hF, 17'h20,    SW_LAT,     4'hF, 4'h0, 32'h20});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].key, vecs[i].sw, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i), vecs[i].expBtn, vecs[i].expPress, vecs[i].expSw);
    end

    // KEY[1] low for 7 cycles: one short of acceptance, must be ignored.
    glitchCnt = 0;
    KEY = 4'hD;
    for (int c = 0; c < 27; c++) begin
      if (c == DC - 1) KEY = 4'hF;
      step(1);
      if (io_btn[1] !== 1'b1 || btn_press[1] !== 1'b0) glitchCnt++;
    end
    checkVal("k1_short_glitch", 32'(glitchCnt), 32'(0));

    // KEY[1] low for exactly 8 cycles: just long enough to be accepted.
    fallAt = -1; pressAt = -1; pressCnt = 0;
    KEY = 4'hD;
    for (int c = 0; c < 30; c++) begin
      if (c == DC) KEY = 4'hF;
      step(1);
      if (fallAt < 0 && io_btn[1] === 1'b0) fallAt = c + 1;
      if (btn_press[1] === 1'b1) begin
        pressCnt++;
        pressAt = c + 1;
      end
    end
    checkVal("k1_boundary_fall_edge",  32'(fallAt),   32'(DC + 2));
    checkVal("k1_boundary_press_edge", 32'(pressAt),  32'(DC + 2));
    checkVal("k1_boundary_press_cnt",  32'(pressCnt), 32'(1));
    checkVal("k1_boundary_released",   32'(io_btn),   32'(4'hF));

    // KEY[2] bounces every 3 cycles for 24 cycles, then is held low.
    fallAt = -1; pressAt = -1; pressCnt = 0; fallCnt = 0;
    prevBtn = io_btn[2];
    for (int c = 0; c < 24; c++) begin
      if (c % 3 == 0) KEY[2] = ~KEY[2];
      step(1);
      if (prevBtn === 1'b1 && io_btn[2] === 1'b0) fallCnt++;
      if (btn_press[2] === 1'b1) pressCnt++;
      prevBtn = io_btn[2];
    end
    KEY[2] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (prevBtn === 1'b1 && io_btn[2] === 1'b0) begin
        fallCnt++;
        fallAt = c + 1;
      end
      if (btn_press[2] === 1'b1) begin
        pressCnt++;
        pressAt = c + 1;
      end
      prevBtn = io_btn[2];
    end
    checkVal("k2_bounce_fall_cnt",   32'(fallCnt),  32'(1));
    checkVal("k2_bounce_fall_edge",  32'(fallAt),   32'(DC + 2));
    checkVal("k2_bounce_press_cnt",  32'(pressCnt), 32'(1));
    checkVal("k2_bounce_press_edge", 32'(pressAt),  32'(DC + 2));
    KEY = 4'hF;
    step(DC + 4);
    checkVal("k2_released", 32'(io_btn), 32'(4'hF));

    // KEY[3] held low, reset pulsed mid-count, KEY[3] kept low throughout.
    KEY = 4'h7;
    step(5);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async", 4'hF, 4'h0, 32'h0);
    step(2);
    checkOutput("rst_held", 4'hF, 4'h0, 32'h0);
    #2 rst = 1'b0;
    fallAt = -1; pressAt = -1; pressCnt = 0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      if (fallAt < 0 && io_btn[3] === 1'b0) fallAt = c + 1;
      if (btn_press[3] === 1'b1) begin
        pressCnt++;
        pressAt = c + 1;
      end
      if (c + 1 == SW_LAT - 1) checkVal("rst_sw_before", io_sw, 32'h0);
      if (c + 1 == SW_LAT)     checkVal("rst_sw_after",  io_sw, 32'h20);
    end
    checkVal("k3_rst_fall_edge",  32'(fallAt),   32'(DC + 2));
    checkVal("k3_rst_press_edge", 32'(pressAt),  32'(DC + 2));
    checkVal("k3_rst_press_cnt",  32'(pressCnt), 32'(1));
    checkVal("k3_rst_final_btn",  32'(io_btn),   32'(4'h7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
